// File: rtl/apb_master_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_master_bridge_pkg : shared types for the APB master bridge       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package apb_master_bridge_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_mst_state_e;

   typedef struct packed {
      logic                  write;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
   } apb_cmd_s;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] rdata;
      logic                  slverr;
      logic                  timeout;
   } apb_rsp_s;

endpackage
`default_nettype wire

// File: rtl/apb_timeout_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_timeout_cnt : counts ACCESS cycles, flags the last allowed one   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module apb_timeout_cnt #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   generate
      if (TIMEOUT > 0) begin : g_timeout
         localparam int                c_CNT_W = $clog2(TIMEOUT + 1);
         localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT - 1);

         logic [c_CNT_W-1:0] r_count;

         always_ff @(posedge clk) begin
            if (rst || i_clear)
               r_count <= '0;
            else if (i_enable)
               r_count <= r_count + c_CNT_W'(1);
         end

         // Expires during the TIMEOUT-th enabled cycle
         assign o_expire = i_enable && (r_count == c_LAST);
      end else begin : g_no_timeout
         assign o_expire = 1'b0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_master_bridge : valid/ready command channel to APB3 master       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module apb_master_bridge
   import apb_master_bridge_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_slverr,
   output logic              rsp_timeout,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   apb_mst_state_e r_state;
   apb_mst_state_e w_next;
   logic           w_in_access;
   logic           w_expire;

   assign w_in_access = (r_state == ACCESS);
   assign cmd_ready   = presetn && (r_state == IDLE);

   apb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .clk      (pclk),
      .rst      (!presetn),
      .i_clear  (!w_in_access),
      .i_enable (w_in_access),
      .o_expire (w_expire)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (cmd_valid)           w_next = SETUP;
         SETUP:                            w_next = ACCESS;
         ACCESS:  if (pready || w_expire)  w_next = RESP;
         RESP:    if (rsp_ready)           w_next = IDLE;
         default:                          w_next = IDLE;
      endcase
   end

   // APB and response strobes are decoded from the next state so they are registered
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         r_state     <= IDLE;
         psel        <= 1'b0;
         penable     <= 1'b0;
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_slverr  <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         r_state   <= w_next;
         psel      <= (w_next == SETUP) || (w_next == ACCESS);
         penable   <= (w_next == ACCESS);
         rsp_valid <= (w_next == RESP);

         if (r_state == IDLE && cmd_valid) begin
            paddr  <= cmd_addr;
            pwrite <= cmd_write;
            pwdata <= cmd_wdata;
         end

         // pready wins over a coincident timeout
         if (w_in_access) begin
            if (pready) begin
               rsp_rdata   <= pwrite ? '0 : prdata;
               rsp_slverr  <= pslverr;
               rsp_timeout <= 1'b0;
            end else if (w_expire) begin
               rsp_rdata   <= '0;
               rsp_slverr  <= 1'b1;
               rsp_timeout <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_apb_master_bridge : directed self-checking bench for the bridge   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_apb_master_bridge;
   import apb_master_bridge_pkg::*;

   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;

   logic              pclk = 1'b0;
   logic              presetn;
   logic              cmd_valid, cmd_ready, cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid, rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_slverr, rsp_timeout;
   logic              psel, penable, pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready, pslverr;

   int checks = 0;
   int errors = 0;

   apb_master_bridge #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .pclk        (pclk),
      .presetn     (presetn),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_slverr  (rsp_slverr),
      .rsp_timeout (rsp_timeout),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .paddr       (paddr),
      .pwdata      (pwdata),
      .prdata      (prdata),
      .pready      (pready),
      .pslverr     (pslverr)
   );

   always #5 pclk = ~pclk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   // Present a command, accept it at the next edge and check the SETUP cycle
   task automatic issue(input apb_cmd_s c);
      check_eq("cmd_ready_idle", cmd_ready, 1'b1);
      cmd_valid = 1'b1;
      cmd_write = c.write;
      cmd_addr  = c.addr;
      cmd_wdata = c.wdata;
      step();
      cmd_valid = 1'b0;
      cmd_addr  = 8'hFF;
      cmd_wdata = 32'h0BAD_0BAD;
      check_eq("setup_psel_pen", {psel, penable}, 2'b10);
      check_eq("setup_addr", paddr, c.addr);
      check_eq("setup_write", pwrite, c.write);
      if (c.write) check_eq("setup_wdata", pwdata, c.wdata);
      check_eq("setup_cmd_ready", cmd_ready, 1'b0);
   endtask

   // Slave holds pready low for 'waits' ACCESS cycles, returns number of ACCESS cycles seen
   task automatic run_access(input apb_cmd_s c, input int waits, input logic err,
                             input logic [DATA_W-1:0] rd, output int acc);
      acc = 0;
      step();
      while (!rsp_valid && acc < 40) begin
         acc++;
         check_eq("access_psel_pen", {psel, penable}, 2'b11);
         check_eq("access_addr", paddr, c.addr);
         if (acc > waits) begin
            pready = 1'b1; prdata = rd;           pslverr = err;
         end else begin
            pready = 1'b0; prdata = 32'h5555_5555; pslverr = 1'b1;
         end
         step();
      end
      pready = 1'b0; prdata = 32'h0; pslverr = 1'b0;
      check_eq("rsp_valid_seen", rsp_valid, 1'b1);
      check_eq("resp_psel_pen", {psel, penable}, 2'b00);
   endtask

   task automatic check_rsp(input apb_rsp_s e);
      check_eq("rsp_rdata", rsp_rdata, e.rdata);
      check_eq("rsp_slverr", rsp_slverr, e.slverr);
      check_eq("rsp_timeout", rsp_timeout, e.timeout);
   endtask

   // Hold rsp_ready low for 'hold' cycles, then complete the handshake
   task automatic finish_rsp(input int hold, input apb_rsp_s e);
      rsp_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         step();
         check_eq("bp_rsp_valid", rsp_valid, 1'b1);
         check_eq("bp_cmd_ready", cmd_ready, 1'b0);
         check_rsp(e);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check_eq("post_rsp_valid", rsp_valid, 1'b0);
      check_eq("post_cmd_ready", cmd_ready, 1'b1);
   endtask

   initial begin
      apb_cmd_s c;
      apb_rsp_s e;
      int       acc;

      presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
      repeat (3) step();
      check_eq("rst_outputs",
               {psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout},
               '0);
      check_eq("rst_cmd_ready", cmd_ready, 1'b0);
      presetn = 1'b1;
      #1;
      check_eq("cmd_ready_after_rst", cmd_ready, 1'b1);

      // Write, zero-wait slave; prdata nonzero must not leak into a write response
      c = '{write: 1'b1, addr: 8'h10, wdata: 32'hDEADBEEF};
      issue(c);
      run_access(c, 0, 1'b0, 32'h1234_5678, acc);
      check_eq("wr_access_cycles", acc, 1);
      e = '{rdata: 32'h0, slverr: 1'b0, timeout: 1'b0};
      check_rsp(e);
      finish_rsp(0, e);
      check_eq("wr_addr_held", paddr, 8'h10);
      check_eq("wr_wdata_held", pwdata, 32'hDEADBEEF);

      // Read back the written word
      c = '{write: 1'b0, addr: 8'h10, wdata: 32'h0};
      issue(c);
      run_access(c, 0, 1'b0, 32'hDEADBEEF, acc);
      check_eq("rd_access_cycles", acc, 1);
      e = '{rdata: 32'hDEADBEEF, slverr: 1'b0, timeout: 1'b0};
      check_rsp(e);
      finish_rsp(0, e);

      // Three wait states then pslverr
      c = '{write: 1'b0, addr: 8'h24, wdata: 32'h0};
      issue(c);
      run_access(c, 3, 1'b1, 32'hCAFEF00D, acc);
      check_eq("ws_access_cycles", acc, 4);
      e = '{rdata: 32'hCAFEF00D, slverr: 1'b1, timeout: 1'b0};
      check_rsp(e);
      finish_rsp(0, e);

      // Timeout with pready stuck low, response back-pressured for 5 cycles
      c = '{write: 1'b1, addr: 8'h3C, wdata: 32'hA5A5_0001};
      issue(c);
      run_access(c, 1000, 1'b0, 32'h0, acc);
      check_eq("to_access_cycles", acc, TIMEOUT);
      e = '{rdata: 32'h0, slverr: 1'b1, timeout: 1'b1};
      check_rsp(e);
      finish_rsp(5, e);

      // pready arriving on the last allowed cycle completes normally
      c = '{write: 1'b0, addr: 8'h44, wdata: 32'h0};
      issue(c);
      run_access(c, TIMEOUT - 1, 1'b0, 32'h0F0F_F0F0, acc);
      check_eq("edge_access_cycles", acc, TIMEOUT);
      e = '{rdata: 32'h0F0F_F0F0, slverr: 1'b0, timeout: 1'b0};
      check_rsp(e);
      finish_rsp(0, e);

      // Reset during ACCESS drops the transfer
      c = '{write: 1'b1, addr: 8'h50, wdata: 32'h7777_8888};
      issue(c);
      step();
      check_eq("pre_rst_access", {psel, penable}, 2'b11);
      presetn = 1'b0;
      step();
      check_eq("mid_rst_outputs", {psel, penable, rsp_valid}, 3'b000);
      check_eq("mid_rst_cmd_ready", cmd_ready, 1'b0);
      step();
      presetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("post_rst_no_rsp", {rsp_valid, psel}, 2'b00);
      end
      c = '{write: 1'b0, addr: 8'h60, wdata: 32'h0};
      issue(c);
      run_access(c, 1, 1'b0, 32'h1357_9BDF, acc);
      check_eq("post_rst_cycles", acc, 2);
      e = '{rdata: 32'h1357_9BDF, slverr: 1'b0, timeout: 1'b0};
      check_rsp(e);
      finish_rsp(0, e);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // penable must never be high without psel
   always @(negedge pclk) begin
      if (penable && !psel) begin
         errors++;
         $display("FAIL penable_without_psel actual=%b%b expected=psel high", psel, penable);
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream stage of the APB slave: converts single-beat commands on a valid/ready request channel into APB3 transfers (SETUP/ACCESS).
- Returns read data and error status on a valid/ready response channel.
- Handles slave wait states via pready and aborts transfers whose pready never arrives, using a programmable timeout.

Parameters:
- ADDR_W, 8, width of paddr and cmd_addr
- DATA_W, 32, width of pwdata/prdata/cmd_wdata/rsp_rdata
- TIMEOUT, 16, maximum ACCESS cycles waiting for pready before abort; 0 disables the timeout

Ports:
- pclk  in  1  clock, all logic on rising edge
- presetn  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  bridge accepts command this cycle
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  read data (0 for writes/timeouts)
- rsp_slverr  out  1  pslverr captured, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB error

Behaviour:
- Reset (presetn=0 at rising edge):
  - State goes to IDLE.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout all go to 0; timeout counter clears.
  - cmd_ready is forced to 0 while presetn=0.
- All outputs are registered except cmd_ready = presetn && (state==IDLE).
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, register paddr/pwrite/pwdata from cmd_* and go to SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0. Go to ACCESS.
- ACCESS: psel=1, penable=1; the counter increments each cycle.
  - pready=1: capture rsp_rdata = pwrite ? 0 : prdata, rsp_slverr=pslverr, rsp_timeout=0; go to RESP.
  - pready=0 and counter==TIMEOUT-1 (TIMEOUT>0): abort with rsp_rdata=0, rsp_slverr=1, rsp_timeout=1; go to RESP.
  - If pready and timeout coincide, pready wins (normal completion).
- RESP: psel=0, penable=0, rsp_valid=1; response fields hold stable. On rsp_ready, rsp_valid drops next cycle and state goes to IDLE.
- Stability:
  - paddr/pwrite/pwdata are constant from SETUP through ACCESS completion.
  - After a transfer they keep their last value until the next accepted command.
  - penable is never 1 without psel.
- Latency with a zero-wait slave:
  - Command accepted at edge N.
  - SETUP in cycle N+1, ACCESS in cycle N+2.
  - rsp_valid high from N+3.
  - Minimum issue interval is 4 cycles (single outstanding transfer).
- pslverr and prdata are sampled only in ACCESS with pready=1; ignored otherwise.
- Reset mid-operation: the in-flight transfer is dropped and no response is produced. psel/penable are low the cycle after the reset edge.

Decomposition:
- Shared package pkg holds:
  - typedef enum logic[1:0] apb_mst_state_e {IDLE, SETUP, ACCESS, RESP}
  - default ADDR_W/DATA_W constants
  - struct apb_cmd_s {write, addr, wdata} and struct apb_rsp_s {rdata, slverr, timeout}, reused by bench transactions
- One sub-module: apb_timeout_cnt (clear/enable/expire), with $clog2(TIMEOUT+1)-bit width and expire tied 0 when TIMEOUT=0.

Test Plan:
- Write, zero-wait slave: cmd addr=0x10 wdata=0xDEADBEEF -> psel cycle N+1, penable N+2, pwrite=1, paddr=0x10; rsp_valid at N+3 with slverr=0, rdata=0.
- Read after write: read addr=0x10 -> rsp_rdata=0xDEADBEEF; paddr stable across SETUP/ACCESS; cmd_ready low until rsp handshake.
- Wait states and error: slave holds pready=0 for 3 ACCESS cycles, then pready=1 with pslverr=1 -> ACCESS lasts 4 cycles; rsp_slverr=1, rsp_timeout=0.
- Timeout: TIMEOUT=16, pready stuck 0 -> abort after 16 ACCESS cycles; rsp_slverr=1, rsp_timeout=1, rdata=0; psel low in RESP.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and fields held; no new command accepted; on rsp_ready=1, IDLE next cycle.
- Reset mid-ACCESS: presetn=0 for 2 cycles during ACCESS -> psel/penable/rsp_valid 0 after the edge; no response emitted; next command completes normally.
